// File: rtl/raisin64_sched_pkg.sv
// Shared definitions for the Raisin64 issue-stage scheduler: unit class codes,
// the execution-class enum and the decode helper that maps type/unit onto a class.
package raisin64_sched_pkg;

  localparam logic [2:0] UNIT_ADVINT_MEM = 3'd4;
  localparam logic [2:0] UNIT_MEM_LD2    = 3'd5;
  localparam logic [2:0] UNIT_STORE      = 3'd6;
  localparam logic [2:0] UNIT_BRANCH     = 3'd7;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALU,
    CLS_ADVINT,
    CLS_MEM,
    CLS_BRANCH
  } sched_class_e;

  // Branch takes priority over the memory group; type=0 with unit 5/6 maps to nothing.
  function automatic sched_class_e decode_class(input logic in_type, input logic [2:0] unit);
    if (!unit[2]) return CLS_ALU;
    if (unit == UNIT_BRANCH) return CLS_BRANCH;
    if (in_type) return CLS_MEM;
    if (unit == UNIT_ADVINT_MEM) return CLS_ADVINT;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/sched_scoreboard.sv
// Register busy scoreboard: NUM_WB writeback clear ports, two issue set ports,
// and ready lookups for four register numbers that include same-cycle writeback bypass.
module sched_scoreboard
  import raisin64_sched_pkg::*;
#(
  parameter int NUM_WB = 2,
  parameter int REG_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_WB-1:0]       fin_valid,
  input  logic [NUM_WB*REG_W-1:0] fin_rn,
  input  logic                    set_a_en,
  input  logic [REG_W-1:0]        set_a_rn,
  input  logic                    set_b_en,
  input  logic [REG_W-1:0]        set_b_rn,
  input  logic [REG_W-1:0]        r1_rn,
  input  logic [REG_W-1:0]        r2_rn,
  input  logic [REG_W-1:0]        rd_rn,
  input  logic [REG_W-1:0]        rd2_rn,
  output logic                    r1_ready,
  output logic                    r2_ready,
  output logic                    rd_ready,
  output logic                    rd2_ready
);

  localparam int DEPTH = 1 << REG_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  function automatic logic is_ready(input logic [REG_W-1:0] rn,
                                    input logic [DEPTH-1:0] b,
                                    input logic [NUM_WB-1:0] fv,
                                    input logic [NUM_WB*REG_W-1:0] fr);
    logic hit;
    hit = (rn == '0) || !b[rn];
    for (int i = 0; i < NUM_WB; i++) begin
      if (fv[i] && (fr[i*REG_W +: REG_W] == rn)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign r1_ready  = is_ready(r1_rn, busy, fin_valid, fin_rn);
  assign r2_ready  = is_ready(r2_rn, busy, fin_valid, fin_rn);
  assign rd_ready  = is_ready(rd_rn, busy, fin_valid, fin_rn);
  assign rd2_ready = is_ready(rd2_rn, busy, fin_valid, fin_rn);

  // Clears are applied before sets so an issue to a finishing register keeps it busy.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NUM_WB; i++) begin
      if (fin_valid[i]) busy_next[fin_rn[i*REG_W +: REG_W]] = 1'b0;
    end
    if (set_a_en) busy_next[set_a_rn] = 1'b1;
    if (set_b_en) busy_next[set_b_rn] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/schedule_mp.sv
// Single-issue scheduler: checks operand/WAW hazards against the scoreboard and
// issues one instruction per cycle to a round-robin ALU, advint, memunit or branch unit.
module schedule_mp
  import raisin64_sched_pkg::*;
#(
  parameter int N_ALU          = 2,
  parameter int NUM_WB         = 2,
  parameter int REG_W          = 6,
  parameter int STARTUP_CYCLES = 1,
  parameter int CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_type,
  input  logic [2:0]              in_unit,
  input  logic [REG_W-1:0]        r1_in_rn,
  input  logic [REG_W-1:0]        r2_in_rn,
  input  logic [REG_W-1:0]        rd_in_rn,
  input  logic [REG_W-1:0]        rd2_in_rn,
  output logic                    will_issue,
  input  logic [NUM_WB-1:0]       fin_valid,
  input  logic [NUM_WB*REG_W-1:0] fin_rn,
  input  logic                    flush,
  input  logic [N_ALU-1:0]        alu_busy,
  input  logic                    advint_busy,
  input  logic                    memunit_busy,
  input  logic                    branch_busy,
  output logic [N_ALU-1:0]        alu_en,
  output logic                    advint_en,
  output logic                    memunit_en,
  output logic                    branch_en,
  output logic [REG_W-1:0]        rd_out_rn,
  output logic [REG_W-1:0]        rd2_out_rn,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int RR_W = (N_ALU > 1) ? $clog2(N_ALU) : 1;

  sched_class_e     cls;
  logic [RR_W-1:0]  rr;
  logic [RR_W-1:0]  alu_sel;
  logic             alu_found;
  logic [3:0]       start_cnt;
  logic             startup_done;
  logic             r1_ready, r2_ready, rd_ready, rd2_ready;
  logic             unit_free;
  logic             no_waw;
  logic             is_store;
  logic             set_a_en, set_b_en;

  assign cls          = decode_class(in_type, in_unit);
  assign startup_done = (start_cnt == 4'd0);
  assign is_store     = (cls == CLS_MEM) && (in_unit == UNIT_STORE);

  // Rotate-and-priority-encode: first free ALU at or after the round-robin pointer.
  always_comb begin
    alu_found = 1'b0;
    alu_sel   = '0;
    for (int k = 0; k < N_ALU; k++) begin
      int idx;
      idx = (int'(rr) + k) % N_ALU;
      if (!alu_found && !alu_busy[RR_W'(idx)]) begin
        alu_found = 1'b1;
        alu_sel   = RR_W'(idx);
      end
    end
  end

  always_comb begin
    unit_free = 1'b0;
    case (cls)
      CLS_ALU:    unit_free = alu_found;
      CLS_ADVINT: unit_free = !advint_busy;
      CLS_MEM:    unit_free = !memunit_busy;
      CLS_BRANCH: unit_free = !branch_busy;
      default:    unit_free = 1'b0;
    endcase
  end

  assign no_waw     = rd_ready && ((cls != CLS_ADVINT) || rd2_ready);
  assign will_issue = in_valid && !flush && startup_done && r1_ready && r2_ready &&
                      no_waw && unit_free;

  assign set_a_en = will_issue && (rd_in_rn != '0) && !is_store;
  assign set_b_en = will_issue && (cls == CLS_ADVINT) && (rd2_in_rn != '0);

  sched_scoreboard #(
    .NUM_WB(NUM_WB),
    .REG_W (REG_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .fin_valid(fin_valid),
    .fin_rn   (fin_rn),
    .set_a_en (set_a_en),
    .set_a_rn (rd_in_rn),
    .set_b_en (set_b_en),
    .set_b_rn (rd2_in_rn),
    .r1_rn    (r1_in_rn),
    .r2_rn    (r2_in_rn),
    .rd_rn    (rd_in_rn),
    .rd2_rn   (rd2_in_rn),
    .r1_ready (r1_ready),
    .r2_ready (r2_ready),
    .rd_ready (rd_ready),
    .rd2_ready(rd2_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_en     <= '0;
      advint_en  <= 1'b0;
      memunit_en <= 1'b0;
      branch_en  <= 1'b0;
      rd_out_rn  <= '0;
      rd2_out_rn <= '0;
      rr         <= '0;
      start_cnt  <= 4'(STARTUP_CYCLES);
      stall_cnt  <= '0;
    end else begin
      alu_en     <= (will_issue && cls == CLS_ALU) ? (N_ALU'(1) << alu_sel) : '0;
      advint_en  <= will_issue && (cls == CLS_ADVINT);
      memunit_en <= will_issue && (cls == CLS_MEM);
      branch_en  <= will_issue && (cls == CLS_BRANCH);
      if (will_issue) rd_out_rn <= rd_in_rn;
      if (will_issue && cls == CLS_ADVINT) rd2_out_rn <= rd2_in_rn;
      if (will_issue && cls == CLS_ALU) rr <= RR_W'((int'(alu_sel) + 1) % N_ALU);
      if (!startup_done) start_cnt <= start_cnt - 4'd1;
      // Saturating count of cycles where an instruction was offered but held back.
      if (in_valid && !will_issue && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
